// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle event strobes: press,
// release, click (short press), long press and auto-repeat while held.
//
// Parameters:
//   LONG_CYCLES   - cycles from the press strobe to the long-press strobe (>= 2)
//   REPEAT_CYCLES - cycles between auto-repeat strobes after a long press; 0 disables
//   CNT_WIDTH     - hold-counter width, must hold max(LONG_CYCLES, REPEAT_CYCLES) - 1
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous active-high reset
//   dataIn       - debounced button level, 1 = pressed
//   pressPulse   - strobe on a detected press
//   releasePulse - strobe on release of a tracked press
//   clickPulse   - strobe on release of a press that never reached long-press
//   longPulse    - strobe when the hold reaches LONG_CYCLES
//   repeatPulse  - strobe every REPEAT_CYCLES while held past long-press
//   holding      - level, high while in the held state
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_WIDTH     = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic dataIn,
    output logic pressPulse,
    output logic releasePulse,
    output logic clickPulse,
    output logic longPulse,
    output logic repeatPulse,
    output logic holding
);

    localparam int unsigned LongLastInt = LONG_CYCLES - 1;
    localparam int unsigned RepLastInt  = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;
    localparam logic [CNT_WIDTH-1:0] LongLast = LongLastInt[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] RepLast  = RepLastInt[CNT_WIDTH-1:0];
    localparam bit RepeatEn = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 prev_q;
    logic                 rise;

    logic press_d, release_d, click_d, long_d, repeat_d, holding_d;

    assign rise = dataIn & ~prev_q;

    // State register; prev_q resets to 1 so a button held through reset is
    // ignored until it is released and pressed again.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            prev_q       <= 1'b1;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            clickPulse   <= 1'b0;
            longPulse    <= 1'b0;
            repeatPulse  <= 1'b0;
            holding      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= dataIn;
            pressPulse   <= press_d;
            releasePulse <= release_d;
            clickPulse   <= click_d;
            longPulse    <= long_d;
            repeatPulse  <= repeat_d;
            holding      <= holding_d;
        end
    end

    // Next-state and hold counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end
            end
            StPressed: begin
                // Release wins over the long threshold on the same edge.
                if (!dataIn) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!dataIn) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (RepeatEn && cnt_q == RepLast) begin
                    cnt_d = '0;
                end else if (RepeatEn) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                press_d = rise;
            end
            StPressed: begin
                if (!dataIn) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == LongLast) begin
                    long_d = 1'b1;
                end
            end
            StHeld: begin
                if (!dataIn) begin
                    release_d = 1'b1;
                end else if (RepeatEn && cnt_q == RepLast) begin
                    repeat_d = 1'b1;
                end
            end
            default: ;
        endcase
        holding_d = (state_d == StHeld);
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the Debouncer and consumes its clean `dataOut` level.
- Converts that level into single-cycle event strobes for the control logic: press, release, click (short press), long press, and auto-repeat while held.
- Gives the user-input path one place to derive button events, so no consumer does its own edge or hold timing.

Parameters:
- LONG_CYCLES, default 50_000_000: clock cycles from the press strobe to the long-press strobe. Must be >= 2.
- REPEAT_CYCLES, default 10_000_000: cycles between auto-repeat strobes after a long press. 0 disables auto-repeat.
- CNT_WIDTH, default 26: hold-counter width. Must hold max(LONG_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  1  debounced button level from the Debouncer; 1 = pressed. Already synchronous to clock.
- pressPulse  output  1  one-cycle strobe on a detected press.
- releasePulse  output  1  one-cycle strobe on release of a tracked press.
- clickPulse  output  1  one-cycle strobe on release of a press that never reached long-press; coincides with releasePulse.
- longPulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.
- repeatPulse  output  1  one-cycle strobe every REPEAT_CYCLES while held past long-press.
- holding  output  1  level; 1 while in state HELD.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) forces: state=IDLE, cnt=0, prevIn=1, all outputs 0.
  - prevIn=1 means a button held through reset produces no events until it is released and pressed again.
- Edge detect: rise = dataIn & ~prevIn. prevIn <= dataIn every non-reset cycle.
- Timing origin: E = the clock edge at which rise is sampled.
- State IDLE:
  - rise -> state PRESSED, cnt <= 0, pressPulse <= 1 at edge E.
  - Falling edges in IDLE are ignored; no releasePulse.
- State PRESSED, each edge:
  - dataIn=0 -> releasePulse=1, clickPulse=1, state IDLE, cnt <= 0. Release has priority over the long threshold.
  - Else if cnt == LONG_CYCLES-1 -> longPulse=1, state HELD, cnt <= 0. longPulse fires at edge E+LONG_CYCLES.
  - Else cnt <= cnt+1.
- State HELD:
  - holding=1.
  - dataIn=0 -> releasePulse=1, clickPulse=0, state IDLE, cnt <= 0, holding <= 0.
  - Else if REPEAT_CYCLES != 0 and cnt == REPEAT_CYCLES-1 -> repeatPulse=1, cnt <= 0.
    - Repeats fire at E+LONG_CYCLES+k*REPEAT_CYCLES, k >= 1.
  - Else if REPEAT_CYCLES != 0 -> cnt <= cnt+1.
  - If REPEAT_CYCLES == 0 the counter holds and no repeats fire.
- Strobe and counter rules:
  - Every strobe is high for exactly one cycle.
  - At most one of pressPulse, longPulse, repeatPulse is high in a cycle.
  - clickPulse is high only together with releasePulse.
  - The counter never wraps past its threshold; it is compared for equality and cleared.
- Re-press: rise in the cycle immediately after a release is a new press with its own full timing. Minimum press/release spacing is 1 cycle.
- Reset mid-operation: on the next edge all strobes and holding clear, the state goes to IDLE, and no releasePulse is emitted.

Test Plan:
Bench uses LONG_CYCLES=8, REPEAT_CYCLES=4, 10 ns clock.
- Short press: reset 2 cycles; dataIn 0->1 sampled at edge E; held 3 cycles; dataIn->0 sampled at edge E+3.
  -> pressPulse at E only; releasePulse and clickPulse at E+3; longPulse never; holding stays 0.
- Long hold with repeat: dataIn=1 from E for 20 cycles.
  -> pressPulse at E; longPulse at E+8; holding=1 from E+8; repeatPulse at E+12, E+16, E+20 if still held.
  -> On release: releasePulse=1, clickPulse=0, holding=0 the same edge.
- Release on the threshold: dataIn->0 sampled at E+8.
  -> releasePulse and clickPulse at E+8; no longPulse; holding never 1.
- Held through reset: dataIn=1 while reset high and after it drops; then release; then press again.
  -> No pulses until the new rise; then pressPulse is normal. No releasePulse for the first release.
- REPEAT_CYCLES=0 variant: hold 30 cycles.
  -> longPulse at E+8 only; no repeatPulse; holding=1 until release.
- Reset asserted at E+10 while HELD.
  -> Next edge: all outputs 0, state IDLE. After reset drops with dataIn still 1: no pressPulse.
